// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between two requesters.
// Define ALU_TWO_CYCLE_EN to stretch EXEC to two cycles for a registered/slower ALU.
//
// state | meaning
// IDLE  | arbitrating; o_req_ready asserted for the granted valid requester
// EXEC  | ALU settling on registered operands
// RESP  | response held until the consumer accepts it
module alu_rr_scheduler #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               clock,
  input  logic               i_rst,
  input  logic [1:0]         i_req_valid,
  output logic [1:0]         o_req_ready,
  input  logic [NB_DATA-1:0] i_req0_data_a,
  input  logic [NB_DATA-1:0] i_req0_data_b,
  input  logic [NB_OP-1:0]   i_req0_op,
  input  logic [NB_DATA-1:0] i_req1_data_a,
  input  logic [NB_DATA-1:0] i_req1_data_b,
  input  logic [NB_OP-1:0]   i_req1_op,
  output logic [NB_DATA-1:0] o_alu_data_a,
  output logic [NB_DATA-1:0] o_alu_data_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_zero,
  input  logic               i_alu_carry,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic               o_rsp_id,
  output logic [NB_DATA-1:0] o_rsp_result,
  output logic               o_rsp_zero,
  output logic               o_rsp_carry,
  output logic               o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   grant;
  logic   req_id;
  logic   handshake;
  logic   exec_done;

`ifdef ALU_TWO_CYCLE_EN
  logic   exec_cnt;
  assign exec_done = (exec_cnt == 1'b0);
`else
  assign exec_done = 1'b1;
`endif

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    grant = i_req_valid[1];
    if (&i_req_valid) grant = ~last_grant;
  end

  assign o_req_ready = (state == IDLE) ? (i_req_valid & {grant, ~grant}) : 2'b00;
  assign handshake   = |o_req_ready;
  assign o_busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (i_rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      req_id       <= 1'b0;
      o_alu_data_a <= '0;
      o_alu_data_b <= '0;
      o_alu_op     <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_zero   <= 1'b0;
      o_rsp_carry  <= 1'b0;
`ifdef ALU_TWO_CYCLE_EN
      exec_cnt     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            o_alu_data_a <= grant ? i_req1_data_a : i_req0_data_a;
            o_alu_data_b <= grant ? i_req1_data_b : i_req0_data_b;
            o_alu_op     <= grant ? i_req1_op     : i_req0_op;
            req_id       <= grant;
            last_grant   <= grant;
            state        <= EXEC;
`ifdef ALU_TWO_CYCLE_EN
            exec_cnt     <= 1'b1;
`endif
          end
        end
        EXEC: begin
          if (exec_done) begin
            o_rsp_result <= i_alu_result;
            o_rsp_zero   <= i_alu_zero;
            o_rsp_carry  <= i_alu_carry;
            o_rsp_id     <= req_id;
            o_rsp_valid  <= 1'b1;
            state        <= RESP;
          end
`ifdef ALU_TWO_CYCLE_EN
          else begin
            exec_cnt <= exec_cnt - 1'b1;
          end
`endif
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios plus randomized traffic checked
// every cycle against a latency/queue model. Honours ALU_TWO_CYCLE_EN.
module tb_alu_rr_scheduler;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
`ifdef ALU_TWO_CYCLE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;

  logic               clock = 1'b0;
  logic               rst;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [NB_DATA-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [NB_OP-1:0]   r0_op, r1_op;
  logic [NB_DATA-1:0] alu_a, alu_b, alu_result;
  logic [NB_OP-1:0]   alu_op;
  logic               alu_zero, alu_carry;
  logic               rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry, busy;
  logic [NB_DATA-1:0] rsp_result;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit started  = 0;

  logic [5:0] ops_tab [6];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Bench-side ALU: returns {carry, result}; SUB carry means borrow.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {(a < b), 8'(a - b)};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_NOR:  return {1'b0, ~(a | b)};
      default: return 9'd0;
    endcase
  endfunction

  assign {alu_carry, alu_result} = alu_f(alu_a, alu_b, alu_op);
  assign alu_zero = (alu_result == 8'd0);

  alu_rr_scheduler #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
    .clock(clock), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req0_data_a(r0_a), .i_req0_data_b(r0_b), .i_req0_op(r0_op),
    .i_req1_data_a(r1_a), .i_req1_data_b(r1_b), .i_req1_op(r1_op),
    .o_alu_data_a(alu_a), .o_alu_data_b(alu_b), .o_alu_op(alu_op),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero), .i_alu_carry(alu_carry),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero), .o_rsp_carry(rsp_carry),
    .o_busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Model: a transaction is "active" from the handshake until the response is taken;
  // its age counts cycles since the handshake and the response is visible at age >= LAT.
  bit         m_active = 0;
  int         m_age    = 0;
  bit         m_last   = 1;
  bit         m_id     = 0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [5:0] m_op = '0;

  initial begin : compare
    logic [1:0] er;
    bit         win;
    bit         erv;
    logic [8:0] cr;
    wait (started);
    forever begin
      @(negedge clock);
      er  = 2'b00;
      win = 0;
      if (!m_active && req_valid != 2'b00) begin
        if (req_valid == 2'b11) win = (m_last == 1'b0);
        else                    win = (req_valid == 2'b10);
        er[win] = 1'b1;
      end
      erv = m_active && (m_age >= LAT);
      chk("ready", req_ready, er);
      chk("busy", busy, m_active);
      chk("rsp_valid", rsp_valid, erv);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
      if (erv) begin
        cr = alu_f(m_a, m_b, m_op);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_result", rsp_result, cr[7:0]);
        chk("rsp_zero", rsp_zero, (cr[7:0] == 8'd0));
        chk("rsp_carry", rsp_carry, cr[8]);
      end
      if (rst) begin
        m_active = 0; m_age = 0; m_last = 1; m_id = 0;
        m_a = '0; m_b = '0; m_op = '0;
      end else if (er != 2'b00) begin
        m_active = 1; m_age = 1; m_id = win; m_last = win;
        m_a  = win ? r1_a  : r0_a;
        m_b  = win ? r1_b  : r0_b;
        m_op = win ? r1_op : r0_op;
      end else if (m_active) begin
        if (erv && rsp_ready) m_active = 0;
        else if (m_age < LAT) m_age++;
      end
    end
  end

  initial begin : stim
    bit         got;
    int         ng, nh;
    bit         grants [4];
    int         hs [3];
    logic [1:0] seen;

    ops_tab[0] = OP_ADD; ops_tab[1] = OP_SUB; ops_tab[2] = OP_AND;
    ops_tab[3] = OP_OR;  ops_tab[4] = OP_XOR; ops_tab[5] = OP_NOR;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    r0_a = '0; r0_b = '0; r0_op = '0; r1_a = '0; r1_b = '0; r1_op = '0;
    tick();
    rst = 1'b0;
    started = 1;

    // 1/6: single ADD from req0
    @(negedge clock);
    chk("s1_reset_busy", busy, 0);
    chk("s1_reset_rsp_valid", rsp_valid, 0);
    chk("s1_reset_alu_op", alu_op, 0);
    tick();
    req_valid = 2'b01; r0_a = 8'h05; r0_b = 8'h03; r0_op = OP_ADD;
    @(negedge clock);
    chk("s1_ready_N", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    @(negedge clock);
    chk("s1_rsp_valid_N1", rsp_valid, 0);
    tick();
    repeat (LAT - 2) tick();
    @(negedge clock);
    chk("s1_rsp_valid_lat", rsp_valid, 1);
    chk("s1_rsp_id", rsp_id, 0);
    chk("s1_result", rsp_result, 8'h08);
    chk("s1_zero", rsp_zero, 0);
    chk("s1_carry", rsp_carry, 0);
    tick();
    repeat (2) tick();

    // 2: both requesters continuously valid
    do_reset();
    req_valid = 2'b11;
    r0_a = 8'hFF; r0_b = 8'h01; r0_op = OP_ADD;
    r1_a = 8'h04; r1_b = 8'h04; r1_op = OP_SUB;
    ng = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (req_ready != 2'b00 && ng < 4) begin
        grants[ng] = req_ready[1];
        ng++;
      end
      if (rsp_valid) begin
        chk("s2_result", rsp_result, 8'h00);
        chk("s2_zero", rsp_zero, 1);
        if (rsp_id == 1'b0) chk("s2_req0_carry", rsp_carry, 1);
      end
      tick();
    end
    req_valid = 2'b00;
    chk("s2_grants_seen", ng, 4);
    for (int i = 0; i < ng; i++) chk("s2_grant_order", grants[i], i % 2);
    repeat (5) tick();

    // 3: backpressure
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 2'b01; r0_a = 8'h10; r0_b = 8'h20; r0_op = OP_ADD;
    @(negedge clock);
    chk("s3_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b10; r1_a = 8'h33; r1_b = 8'h0F; r1_op = OP_XOR;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clock);
      if (rsp_valid) got = 1;
      else tick();
    end
    chk("s3_rsp_rise", got, 1);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clock);
      chk("s3_hold_result", rsp_result, 8'h30);
      chk("s3_hold_valid", rsp_valid, 1);
      chk("s3_hold_ready", req_ready, 2'b00);
      chk("s3_hold_busy", busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    @(negedge clock);
    chk("s3_idle_busy", busy, 0);
    chk("s3_idle_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    repeat (5) tick();

    // 4: reset during EXEC
    do_reset();
    req_valid = 2'b01; r0_a = 8'h05; r0_b = 8'h03; r0_op = OP_ADD;
    tick();
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11;
    r0_a = 8'h01; r0_b = 8'h02; r0_op = OP_OR;
    r1_a = 8'h03; r1_b = 8'h04; r1_op = OP_AND;
    @(negedge clock);
    chk("s4_rsp_valid", rsp_valid, 0);
    chk("s4_busy", busy, 0);
    chk("s4_alu_a", alu_a, 0);
    chk("s4_alu_b", alu_b, 0);
    chk("s4_alu_op", alu_op, 0);
    chk("s4_first_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    repeat (10) tick();
    req_valid = 2'b00;
    repeat (5) tick();

    // 5: only req1, back-to-back
    do_reset();
    req_valid = 2'b10; r1_a = 8'h07; r1_b = 8'h09; r1_op = OP_AND;
    nh = 0;
    for (int c = 0; c < 20 && nh < 3; c++) begin
      @(negedge clock);
      if (rsp_valid) chk("s5_rsp_id", rsp_id, 1);
      if (req_ready[1]) begin
        hs[nh] = cyc;
        nh++;
      end
      tick();
    end
    req_valid = 2'b00;
    chk("s5_handshakes", nh, 3);
    if (nh == 3) begin
      chk("s5_gap1", hs[1] - hs[0], LAT + 1);
      chk("s5_gap2", hs[2] - hs[1], LAT + 1);
    end
    repeat (6) tick();

    // Randomized traffic; requesters hold valid/data until ready, with rare early drops.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      seen = req_ready;
      tick();
      rst = ($urandom_range(0, 249) == 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < 2; k++) begin
        if ((req_valid[k] && seen[k]) || !req_valid[k]) begin
          if (!req_valid[k] || seen[k]) begin
            req_valid[k] = ($urandom_range(0, 2) == 0);
            if (k == 0) begin
              r0_a = 8'($urandom); r0_b = 8'($urandom); r0_op = ops_tab[$urandom_range(0, 5)];
            end else begin
              r1_a = 8'($urandom); r1_b = 8'($urandom); r1_op = ops_tab[$urandom_range(0, 5)];
            end
          end
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid[k] = 1'b0;
        end
      end
    end
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
